// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer driving an external 8-bit SIPO shift register.
// Synchronises rx_in, qualifies the start bit at mid-bit using 16x oversampling,
// strobes each data bit into the SIPO, checks the stop bit and holds the completed
// byte behind a valid/read handshake with sticky overrun.
// Optional feature: define UART_RX_PARITY_EN to add one even-parity bit (8E1);
// a parity mismatch is reported as a frame error and the byte is discarded.
module uart_rx_ctrl #(
  parameter int TICK_DIV = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic [7:0] sipo_data,
  output logic       sipo_din,
  output logic       sipo_shift,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_rd,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       rx_overrun
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, rxs_q;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]       phase_q, phase_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             sipo_din_q, sipo_din_d;
  logic             sipo_shift_q, sipo_shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             tick;
  logic             mid_sample;
  logic             stop_good;
`ifdef UART_RX_PARITY_EN
  logic             parity_err_q, parity_err_d;
`endif

  assign tick       = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
  assign mid_sample = tick && (phase_q == 4'd15);

`ifdef UART_RX_PARITY_EN
  assign stop_good  = rxs_q && !parity_err_q;
`else
  assign stop_good  = rxs_q;
`endif

  // Two-flop synchroniser for the asynchronous line; resets to the idle level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rxs_q   <= sync1_q;
    end
  end

  // Receive state, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      phase_q      <= 4'd0;
      bit_idx_q    <= 3'd0;
      sipo_din_q   <= 1'b1;
      sipo_shift_q <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      phase_q      <= phase_d;
      bit_idx_q    <= bit_idx_d;
      sipo_din_q   <= sipo_din_d;
      sipo_shift_q <= sipo_shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic: frame sequencing, mid-bit sampling and the read handshake
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
    phase_d      = tick ? phase_q + 4'd1 : phase_q;
    bit_idx_d    = bit_idx_q;
    sipo_din_d   = sipo_din_q;
    sipo_shift_d = 1'b0;
    frame_err_d  = 1'b0;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_rd ? 1'b0 : rx_valid_q;
    overrun_d    = rx_rd ? 1'b0 : overrun_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          tick_cnt_d = '0;
          phase_d    = 4'd0;
          bit_idx_d  = 3'd0;
          state_d    = START;
        end
      end
      START: begin
        if (tick && (phase_q == 4'd7)) begin
          if (!rxs_q) begin
            phase_d = 4'd0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (mid_sample) begin
          sipo_din_d   = rxs_q;
          sipo_shift_d = 1'b1;
          bit_idx_d    = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid_sample) begin
          parity_err_d = (^sipo_data) ^ rxs_q;
          state_d      = STOP;
        end
      end
`endif
      STOP: begin
        if (mid_sample) begin
          if (stop_good) begin
            rx_data_d  = sipo_data;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_rd) begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sipo_din   = sipo_din_q;
  assign sipo_shift = sipo_shift_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = overrun_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q != IDLE);

endmodule
